// File: rtl/fd_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fd_pipe_reg_pkg
//  Description : Shared constants and types for the F/D pipeline register.
//                The address map and exception codes here are the same
//                values CP0 uses, so the two blocks agree on where the
//                machine restarts after reset and after an exception.
//  Contents    : c_RESET_ADDR, c_HANDLER_ADDR, c_IM_LO, c_IM_HI,
//                c_EXC_NONE, c_EXC_ADEL, fd_action_e, fd_stage_t,
//                fd_select_action(), fd_bubble()
//  Revision    : 1.0 - initial release
// ============================================================================
package fd_pipe_reg_pkg;

    // Address map
    localparam logic [31:0] c_RESET_ADDR   = 32'h0000_3000;
    localparam logic [31:0] c_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] c_IM_LO        = 32'h0000_3000;
    localparam logic [31:0] c_IM_HI        = 32'h0000_6FFC;

    // Exception codes
    localparam logic [4:0]  c_EXC_NONE     = 5'd0;
    localparam logic [4:0]  c_EXC_ADEL     = 5'd4;

    // What the register does on a given edge when reset is not asserted.
    typedef enum logic [1:0] {
        FD_ACT_LOAD  = 2'd0,
        FD_ACT_HOLD  = 2'd1,
        FD_ACT_FLUSH = 2'd2
    } fd_action_e;

    // Contents of the F/D register as seen by the D stage.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc_code;
        logic        bd;
        logic        valid;
    } fd_stage_t;

    // A flush request beats any hold source; only a quiet pipeline loads.
    function automatic fd_action_e fd_select_action(
        input logic req,
        input logic hold
    );
        fd_action_e act;
        act = FD_ACT_LOAD;
        if (req) begin
            act = FD_ACT_FLUSH;
        end else if (hold) begin
            act = FD_ACT_HOLD;
        end
        return act;
    endfunction

    // An empty slot parked at a known PC. Reset and flush differ only in
    // the PC, which keeps the macro-PC defined while the next fetch is in F.
    function automatic fd_stage_t fd_bubble(input logic [31:0] pc);
        fd_stage_t s;
        s.instr    = 32'h0000_0000;
        s.pc       = pc;
        s.exc_code = c_EXC_NONE;
        s.bd       = 1'b0;
        s.valid    = 1'b0;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fd_fetch_exc_chk.sv
`default_nettype none
// ============================================================================
//  Module      : fd_fetch_exc_chk
//  Description : Fetch address error (AdEL) detector. Purely combinational.
//                A fetch faults when the PC is not word aligned or lies
//                outside the instruction memory window [IM_LO, IM_HI].
//                The comparisons are plain unsigned 32-bit compares, so an
//                address near the top of the space never wraps into range.
//  Parameters  : IM_LO  - lowest legal fetch address
//                IM_HI  - highest legal fetch address (inclusive)
//  Ports       : i_pc   in  32  F-stage fetch address
//                o_adel out  1  1 = fetch address error
//  Revision    : 1.0 - initial release
// ============================================================================
module fd_fetch_exc_chk
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] IM_LO = c_IM_LO,
    parameter logic [31:0] IM_HI = c_IM_HI
) (
    input  logic [31:0] i_pc,
    output logic        o_adel
);

    logic w_misaligned;
    logic w_below;
    logic w_above;

    assign w_misaligned = (i_pc[1:0] != 2'b00);
    assign w_below      = (i_pc < IM_LO);
    assign w_above      = (i_pc > IM_HI);

    assign o_adel = w_misaligned | w_below | w_above;

endmodule
`default_nettype wire

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fd_pipe_reg
//  Description : F/D pipeline register sitting directly after the PC/fetch
//                stage. Captures the fetched word, its PC, any fetch
//                exception and the branch-delay-slot flag for the D stage.
//                Edge priority: reset > Req (flush) > hold > load.
//                Holding freezes every output; the bubble for a stall is
//                inserted further down the pipe, not here.
//  Optional    : FD_PERF_CNT_EN - when defined, adds perf_fetch_cnt and
//                perf_hold_cnt (load / hold cycle counters, cleared by
//                reset only, wrapping modulo 2^32).
//  Ports       : clk        in   1   clock
//                reset      in   1   synchronous active-high reset
//                stall      in   1   hazard stall, hold
//                BUSY       in   1   mult/div busy, hold
//                start      in   1   mult/div start, hold
//                Req        in   1   CP0 request, flush
//                pc_F       in  32   fetch address
//                instr_F    in  32   fetched word
//                is_jb_D    in   1   instruction in D is a branch/jump
//                instr_D    out 32   instruction to decode (0 if bubble/fault)
//                pc_D       out 32   PC of instr_D
//                exc_code_D out  5   pending exception code (0 = none)
//                bd_D       out  1   instr_D is in a delay slot
//                valid_D    out  1   1 = real instruction
//                perf_fetch_cnt out 32  (FD_PERF_CNT_EN only)
//                perf_hold_cnt  out 32  (FD_PERF_CNT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module fd_pipe_reg
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR   = c_RESET_ADDR,
    parameter logic [31:0] HANDLER_ADDR = c_HANDLER_ADDR,
    parameter logic [31:0] IM_LO        = c_IM_LO,
    parameter logic [31:0] IM_HI        = c_IM_HI,
    parameter logic [4:0]  EXC_ADEL     = c_EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        BUSY,
    input  logic        start,
    input  logic        Req,
    input  logic [31:0] pc_F,
    input  logic [31:0] instr_F,
    input  logic        is_jb_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [4:0]  exc_code_D,
    output logic        bd_D,
    output logic        valid_D
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_hold_cnt
`endif
);

    fd_stage_t  r_stage;
    fd_stage_t  w_next;
    fd_action_e w_action;
    logic       w_hold;
    logic       w_adel;

    // Any of the three stall sources freezes the register.
    assign w_hold   = stall | BUSY | start;
    assign w_action = fd_select_action(Req, w_hold);

    fd_fetch_exc_chk #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_exc_chk (
        .i_pc   (pc_F),
        .o_adel (w_adel)
    );

    always_comb begin
        w_next = r_stage;
        case (w_action)
            FD_ACT_FLUSH: begin
                w_next = fd_bubble(HANDLER_ADDR);
            end
            FD_ACT_HOLD: begin
                w_next = r_stage;
            end
            FD_ACT_LOAD: begin
                w_next.pc    = pc_F;
                w_next.bd    = is_jb_D;
                w_next.valid = 1'b1;
                // A faulting fetch still occupies the slot (valid) so CP0
                // sees the exception with the correct PC; the word itself
                // is replaced by a nop so decode does nothing with it.
                if (w_adel) begin
                    w_next.instr    = 32'h0000_0000;
                    w_next.exc_code = EXC_ADEL;
                end else begin
                    w_next.instr    = instr_F;
                    w_next.exc_code = c_EXC_NONE;
                end
            end
            default: begin
                w_next = r_stage;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= fd_bubble(RESET_ADDR);
        end else begin
            r_stage <= w_next;
        end
    end

    assign instr_D    = r_stage.instr;
    assign pc_D       = r_stage.pc;
    assign exc_code_D = r_stage.exc_code;
    assign bd_D       = r_stage.bd;
    assign valid_D    = r_stage.valid;

`ifdef FD_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_hold_cnt;

    // Flush cycles count as neither load nor hold, and Req does not clear
    // the counters: they describe the whole run since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch_cnt <= 32'd0;
            r_perf_hold_cnt  <= 32'd0;
        end else begin
            if (w_action == FD_ACT_LOAD) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_action == FD_ACT_HOLD) begin
                r_perf_hold_cnt <= r_perf_hold_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_hold_cnt  = r_perf_hold_cnt;
`endif

endmodule
`default_nettype wire
